// File: rtl/reset_req_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// reset_req_pkg
// Shared types and constants for the reset request controller.
//   state_t       : controller FSM states
//   REQ_COLD/WARM/DEBUG : bit positions inside hps_reset_req
//   req_onehot()  : builds the one-hot request vector for a bit position
// ---------------------------------------------------------------------------
package reset_req_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_ASSERT   = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

    localparam int REQ_COLD  = 0;
    localparam int REQ_WARM  = 1;
    localparam int REQ_DEBUG = 2;

    function automatic logic [2:0] req_onehot(input int idx);
        logic [2:0] v;
        v      = 3'b000;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/reset_req_ctrl_if.sv
// ---------------------------------------------------------------------------
// reset_req_ctrl_if
// Groups the key inputs and the request/status outputs of reset_req_ctrl.
//   key_n         : raw push-buttons, active-low (bit0 warm/cold, bit1 debug)
//   hps_reset_req : level requests, bit0 cold, bit1 warm, bit2 debug
//   key_pressed   : debounced key state, 1 = pressed
//   busy          : controller is outside IDLE
// master = environment driving the keys, slave = the controller.
// ---------------------------------------------------------------------------
interface reset_req_ctrl_if;
    logic [1:0] key_n;
    logic [2:0] hps_reset_req;
    logic [1:0] key_pressed;
    logic       busy;

    modport master (
        output key_n,
        input  hps_reset_req,
        input  key_pressed,
        input  busy
    );

    modport slave (
        input  key_n,
        output hps_reset_req,
        output key_pressed,
        output busy
    );
endinterface

// File: rtl/reset_req_ctrl_key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Two-flop synchronizer followed by a stability counter for one key.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   i_key_n   : raw asynchronous key, active-low
//   o_pressed : debounced key state, 1 = pressed (registered)
// The debounced level flips only after the synchronized level has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
// ---------------------------------------------------------------------------
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_n,
    output logic o_pressed
);
    localparam int CNT_W_RAW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_pressed;
    logic [CNT_W-1:0] r_cnt;
    logic             w_sync_pressed;

    assign w_sync_pressed = ~r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // synchronizer parks at the released level
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_pressed <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            if (w_sync_pressed != r_pressed) begin
                if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_pressed <= w_sync_pressed;
                    r_cnt     <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                // any agreement (bounce) restarts the count
                r_cnt <= '0;
            end
        end
    end

    assign o_pressed = r_pressed;
endmodule

// File: rtl/reset_req_ctrl.sv
// ---------------------------------------------------------------------------
// reset_req_ctrl
// Turns push-button gestures into HPS reset requests.
//   clk   : single system clock
//   rst_n : asynchronous active-low reset
//   bus   : reset_req_ctrl_if.slave (key_n in; hps_reset_req,
//           key_pressed, busy out)
// key0 short hold -> nothing, hold >= WARM -> warm, hold >= COLD -> cold
// (decided on release); key1 press -> debug. A request is a REQ_CYCLES
// level, followed by a COOLDOWN_CYCLES lockout that also waits for both
// keys to be released so every request needs a fresh press.
// ---------------------------------------------------------------------------
module reset_req_ctrl
    import reset_req_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 1000000,
    parameter int WARM_HOLD_CYCLES = 50000000,
    parameter int COLD_HOLD_CYCLES = 250000000,
    parameter int REQ_CYCLES       = 16,
    parameter int COOLDOWN_CYCLES  = 50000
) (
    input  logic            clk,
    input  logic            rst_n,
    reset_req_ctrl_if.slave bus
);
    localparam int HOLD_W_RAW = $clog2(COLD_HOLD_CYCLES + 1);
    localparam int REQ_W_RAW  = $clog2(REQ_CYCLES + 1);
    localparam int CD_W_RAW   = $clog2(COOLDOWN_CYCLES + 1);
    localparam int HOLD_W     = (HOLD_W_RAW < 1) ? 1 : HOLD_W_RAW;
    localparam int REQ_W      = (REQ_W_RAW < 1) ? 1 : REQ_W_RAW;
    localparam int CD_W       = (CD_W_RAW < 1) ? 1 : CD_W_RAW;

    logic [1:0]        w_key_pressed;
    logic [1:0]        w_rise;
    state_t            r_state;
    logic [1:0]        r_kp_prev;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [REQ_W-1:0]  r_req_cnt;
    logic [CD_W-1:0]   r_cd_cnt;
    logic [2:0]        r_sel;
    logic [2:0]        r_hps_req;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_key_debounce (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_key_n   (bus.key_n[gi]),
                .o_pressed (w_key_pressed[gi])
            );
        end
    endgenerate

    assign w_rise = w_key_pressed & ~r_kp_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_kp_prev  <= 2'b00;
            r_hold_cnt <= '0;
            r_req_cnt  <= '0;
            r_cd_cnt   <= '0;
            r_sel      <= 3'b000;
            r_hps_req  <= 3'b000;
        end else begin
            r_kp_prev <= w_key_pressed;
            case (r_state)
                ST_IDLE: begin
                    // key0 has priority; a simultaneous key1 edge is dropped
                    if (w_rise[0]) begin
                        r_hold_cnt <= '0;
                        r_state    <= ST_HOLD;
                    end else if (w_rise[1]) begin
                        r_sel     <= req_onehot(REQ_DEBUG);
                        r_req_cnt <= '0;
                        r_state   <= ST_ASSERT;
                    end
                end
                ST_HOLD: begin
                    if (!w_key_pressed[0]) begin
                        r_req_cnt <= '0;
                        if (r_hold_cnt >= HOLD_W'(COLD_HOLD_CYCLES)) begin
                            r_sel   <= req_onehot(REQ_COLD);
                            r_state <= ST_ASSERT;
                        end else if (r_hold_cnt >= HOLD_W'(WARM_HOLD_CYCLES)) begin
                            r_sel   <= req_onehot(REQ_WARM);
                            r_state <= ST_ASSERT;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (r_hold_cnt != HOLD_W'(COLD_HOLD_CYCLES)) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                ST_ASSERT: begin
                    // request is driven from the cycle after entry
                    if (r_req_cnt == REQ_W'(REQ_CYCLES)) begin
                        r_hps_req <= 3'b000;
                        r_cd_cnt  <= CD_W'(1);
                        r_state   <= ST_COOLDOWN;
                    end else begin
                        r_hps_req <= r_sel;
                        r_req_cnt <= r_req_cnt + 1'b1;
                    end
                end
                ST_COOLDOWN: begin
                    // r_cd_cnt counts cooldown cycles already spent, first one included
                    if (r_cd_cnt >= CD_W'(COOLDOWN_CYCLES) && w_key_pressed == 2'b00) begin
                        r_state <= ST_IDLE;
                    end else if (r_cd_cnt < CD_W'(COOLDOWN_CYCLES)) begin
                        r_cd_cnt <= r_cd_cnt + 1'b1;
                    end
                end
                default: begin
                    r_hps_req <= 3'b000;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.hps_reset_req = r_hps_req;
    assign bus.key_pressed   = w_key_pressed;
    assign bus.busy          = (r_state != ST_IDLE);
endmodule
